// File: rtl/i2c_target_burst.sv
// I2C target: 7-bit device address, one register-offset byte, then burst writes or reads
// through an auto-incrementing pointer. SCL/SDA are oversampled; SDA is only ever pulled low.
module i2c_target_burst #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h23,
    parameter int unsigned REG_AW      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              SYSTEM_CLK,
    input  logic              RESETn,
    input  logic              SCL,
    inout  wire               SDA,
    input  logic [7:0]        rd_data,
    output logic [REG_AW-1:0] reg_addr,
    output logic [7:0]        wr_data,
    output logic              wr_en,
    output logic              rd_en,
    output logic              busy
);

    typedef enum logic [3:0] {
        StIdle,
        StDevAddr,
        StDevAck,
        StRegAddr,
        StRegAck,
        StWrByte,
        StWrAck,
        StRdByte,
        StRdMack,
        StWaitStop
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_new, scl_old, sda_new, sda_old;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_e              state_q, state_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic [REG_AW-1:0]   ptr_q, ptr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                wr_en_q, wr_en_d;
    logic                rd_en_q, rd_en_d;
    logic                rd_load_q, rd_load_d;
    logic                busy_q, busy_d;
    logic                sda_low_q, sda_low_d;

    // Synchronisers reset to the idle-bus level so reset release cannot fake an edge.
    always_ff @(posedge SYSTEM_CLK or negedge RESETn) begin
        if (!RESETn) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], SCL};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], SDA};
        end
    end

    assign scl_new   = scl_sync_q[SYNC_STAGES-2];
    assign scl_old   = scl_sync_q[SYNC_STAGES-1];
    assign sda_new   = sda_sync_q[SYNC_STAGES-2];
    assign sda_old   = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_new & ~scl_old;
    assign scl_fall  = ~scl_new & scl_old;
    assign start_det = scl_new & scl_old & sda_old & ~sda_new;
    assign stop_det  = scl_new & scl_old & ~sda_old & sda_new;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        rd_load_d = rd_en_q;
        busy_d    = busy_q;
        sda_low_d = sda_low_q;

        if (wr_en_q) begin
            ptr_d = ptr_q + 1'b1;
        end
        // rd_data is valid the cycle after rd_en; load it and present the MSB at once.
        if (rd_load_q) begin
            shift_d   = rd_data;
            sda_low_d = ~rd_data[7];
            ptr_d     = ptr_q + 1'b1;
        end

        unique case (state_q)
            StIdle, StWaitStop: begin
            end
            StDevAddr, StRegAddr, StWrByte: begin
                if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_new};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (scl_fall && bit_cnt_q == 4'd8) begin
                    bit_cnt_d = '0;
                    if (state_q == StDevAddr) begin
                        if (shift_q[7:1] == SLAVE_ADDR && shift_q[7:1] != 7'd0) begin
                            state_d   = StDevAck;
                            sda_low_d = 1'b1;
                            busy_d    = 1'b1;
                        end else begin
                            state_d = StWaitStop;
                        end
                    end else begin
                        sda_low_d = 1'b1;
                        state_d   = (state_q == StRegAddr) ? StRegAck : StWrAck;
                    end
                end
            end
            StDevAck: begin
                if (scl_fall) begin
                    sda_low_d = 1'b0;
                    bit_cnt_d = '0;
                    if (shift_q[0]) begin
                        rd_en_d = 1'b1;
                        state_d = StRdByte;
                    end else begin
                        state_d = StRegAddr;
                    end
                end
            end
            StRegAck: begin
                if (scl_fall) begin
                    sda_low_d = 1'b0;
                    ptr_d     = shift_q[REG_AW-1:0];
                    state_d   = StWrByte;
                end
            end
            StWrAck: begin
                if (scl_fall) begin
                    sda_low_d = 1'b0;
                    wr_en_d   = 1'b1;
                    wr_data_d = shift_q;
                    state_d   = StWrByte;
                end
            end
            StRdByte: begin
                if (scl_rise) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (scl_fall && bit_cnt_q == 4'd8) begin
                    sda_low_d = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = StRdMack;
                end else if (scl_fall && bit_cnt_q != 4'd0) begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    sda_low_d = ~shift_q[6];
                end
            end
            StRdMack: begin
                if (scl_rise && sda_new) begin
                    state_d = StWaitStop;
                    busy_d  = 1'b0;
                end else if (scl_fall) begin
                    rd_en_d   = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = StRdByte;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Bus conditions override everything; a partial byte is simply dropped.
        if (start_det || stop_det) begin
            state_d   = start_det ? StDevAddr : StIdle;
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
            wr_en_d   = 1'b0;
            rd_en_d   = 1'b0;
            rd_load_d = 1'b0;
        end
    end

    always_ff @(posedge SYSTEM_CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_load_q <= 1'b0;
            busy_q    <= 1'b0;
            sda_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            rd_load_q <= rd_load_d;
            busy_q    <= busy_d;
            sda_low_q <= sda_low_d;
        end
    end

    assign SDA      = sda_low_q ? 1'b0 : 1'bz;
    assign reg_addr = ptr_q;
    assign wr_data  = wr_data_q;
    assign wr_en    = wr_en_q;
    assign rd_en    = rd_en_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target_burst.sv
// Directed bench: two targets share one bus (default at 0x23; REG_AW=4, SYNC_STAGES=3 at 0x2A),
// driven by a bit-banged master with SCL at SYSTEM_CLK/10.
`timescale 1ns/1ps
module tb_i2c_target_burst;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic scl;
    logic m_low;
    wire  sda;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    logic [7:0] rd_data_a = 8'h00, rd_data_b = 8'h00;
    logic [7:0] reg_addr_a, wr_data_a, wr_data_b;
    logic [3:0] reg_addr_b;
    logic       wr_en_a, rd_en_a, busy_a, wr_en_b, rd_en_b, busy_b;

    i2c_target_burst #(.SLAVE_ADDR(7'h23), .REG_AW(8), .SYNC_STAGES(2)) dut_a (
        .SYSTEM_CLK(clk), .RESETn(rst_n), .SCL(scl), .SDA(sda), .rd_data(rd_data_a),
        .reg_addr(reg_addr_a), .wr_data(wr_data_a), .wr_en(wr_en_a), .rd_en(rd_en_a),
        .busy(busy_a)
    );

    i2c_target_burst #(.SLAVE_ADDR(7'h2A), .REG_AW(4), .SYNC_STAGES(3)) dut_b (
        .SYSTEM_CLK(clk), .RESETn(rst_n), .SCL(scl), .SDA(sda), .rd_data(rd_data_b),
        .reg_addr(reg_addr_b), .wr_data(wr_data_b), .wr_en(wr_en_b), .rd_en(rd_en_b),
        .busy(busy_b)
    );

    // Register-file models: registered read data one cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= reg_addr_a ^ 8'h5C;
        if (rd_en_b) rd_data_b <= {4'h0, reg_addr_b} ^ 8'hA3;
    end

    int wr_cnt_a = 0, rd_cnt_a = 0, wr_cnt_b = 0, rd_cnt_b = 0;
    int busy_cyc_a = 0, busy_cyc_b = 0, dut_low_cyc = 0;
    logic [7:0] wa_addr [16];
    logic [7:0] wa_data [16];
    logic [7:0] ra_addr [16];
    logic [3:0] wb_addr [16];
    logic [7:0] wb_data [16];
    logic [3:0] rb_addr [16];

    always @(posedge clk) begin
        if (wr_en_a) begin
            wa_addr[wr_cnt_a[3:0]] <= reg_addr_a;
            wa_data[wr_cnt_a[3:0]] <= wr_data_a;
            wr_cnt_a <= wr_cnt_a + 1;
        end
        if (rd_en_a) begin
            ra_addr[rd_cnt_a[3:0]] <= reg_addr_a;
            rd_cnt_a <= rd_cnt_a + 1;
        end
        if (wr_en_b) begin
            wb_addr[wr_cnt_b[3:0]] <= reg_addr_b;
            wb_data[wr_cnt_b[3:0]] <= wr_data_b;
            wr_cnt_b <= wr_cnt_b + 1;
        end
        if (rd_en_b) begin
            rb_addr[rd_cnt_b[3:0]] <= reg_addr_b;
            rd_cnt_b <= rd_cnt_b + 1;
        end
        if (busy_a) busy_cyc_a <= busy_cyc_a + 1;
        if (busy_b) busy_cyc_b <= busy_cyc_b + 1;
        if (sda === 1'b0 && !m_low) dut_low_cyc <= dut_low_cyc + 1;
    end

    int checks = 0, failures = 0, unstable = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        if (scl == 1'b0) begin
            wait_clk(2); m_low = 1'b0; wait_clk(4); scl = 1'b1;
        end
        wait_clk(2); m_low = 1'b1; wait_clk(2); scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(2); m_low = 1'b1; wait_clk(4); scl = 1'b1; wait_clk(2); m_low = 1'b0;
        wait_clk(4);
    endtask

    task automatic put_bit(input logic b);
        wait_clk(2); m_low = ~b; wait_clk(4); scl = 1'b1; wait_clk(4); scl = 1'b0;
    endtask

    // Samples at the SCL rise and again just before the fall to catch late or glitchy data.
    task automatic get_bit(output logic b);
        wait_clk(2); m_low = 1'b0; wait_clk(4);
        b = sda; scl = 1'b1; wait_clk(4);
        if (sda !== b) unstable++;
        scl = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] d, output logic nak);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(nak);
    endtask

    task automatic get_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(~ack);
    endtask

    logic       nak, b;
    logic [7:0] d;
    logic [2:0] bits;
    int         w0, r0, wb0, rb0, ba0, bb0, dl0;

    initial begin
        rst_n = 1'b0; scl = 1'b1; m_low = 1'b0;
        wait_clk(5);
        check("rst_sda", sda, 1'b1);
        check("rst_reg_addr", reg_addr_a, 8'h00);
        check("rst_wr_data", wr_data_a, 8'h00);
        check("rst_strobes", {wr_en_a, rd_en_a, busy_a}, 3'b000);
        rst_n = 1'b1;
        wait_clk(5);

        // Write burst to A
        w0 = wr_cnt_a; wb0 = wr_cnt_b; bb0 = busy_cyc_b;
        bus_start();
        put_byte(8'h46, nak); check("wr_dev_ack", nak, 1'b0);
        check("wr_busy", busy_a, 1'b1);
        put_byte(8'h10, nak); check("wr_reg_ack", nak, 1'b0);
        put_byte(8'hA5, nak); check("wr_d0_ack", nak, 1'b0);
        put_byte(8'h5A, nak); check("wr_d1_ack", nak, 1'b0);
        bus_stop();
        check("wr_count", wr_cnt_a - w0, 2);
        check("wr0", {wa_addr[w0[3:0]], wa_data[w0[3:0]]}, 16'h10A5);
        check("wr1", {wa_addr[w0[3:0] + 4'd1], wa_data[w0[3:0] + 4'd1]}, 16'h115A);
        check("wr_ptr_end", reg_addr_a, 8'h12);
        check("wr_busy_end", busy_a, 1'b0);
        check("wr_other_quiet", {wr_cnt_b - wb0, busy_cyc_b - bb0}, 64'h0);

        // Combined read from A: offset 0x20, Sr, three bytes
        r0 = rd_cnt_a;
        bus_start();
        put_byte(8'h46, nak); check("rd_dev_ack", nak, 1'b0);
        put_byte(8'h20, nak); check("rd_reg_ack", nak, 1'b0);
        bus_start();
        put_byte(8'h47, nak); check("rd_devr_ack", nak, 1'b0);
        get_byte(d, 1'b1); check("rd_byte0", d, 8'h7C);
        get_byte(d, 1'b1); check("rd_byte1", d, 8'h7D);
        get_byte(d, 1'b0); check("rd_byte2", d, 8'h7E);
        wait_clk(4);
        check("rd_sda_released", sda, 1'b1);
        check("rd_busy_after_nack", busy_a, 1'b0);
        bus_stop();
        check("rd_count", rd_cnt_a - r0, 3);
        check("rd_addrs", {ra_addr[r0[3:0]], ra_addr[r0[3:0] + 4'd1], ra_addr[r0[3:0] + 4'd2]},
              24'h202122);
        check("rd_ptr_end", reg_addr_a, 8'h23);

        // Unmatched address 0x24
        w0 = wr_cnt_a; r0 = rd_cnt_a; wb0 = wr_cnt_b; rb0 = rd_cnt_b;
        ba0 = busy_cyc_a; bb0 = busy_cyc_b; dl0 = dut_low_cyc;
        bus_start();
        put_byte(8'h48, nak); check("bad_dev_nak", nak, 1'b1);
        put_byte(8'h12, nak); check("bad_b0_nak", nak, 1'b1);
        put_byte(8'h34, nak); check("bad_b1_nak", nak, 1'b1);
        put_byte(8'h56, nak); check("bad_b2_nak", nak, 1'b1);
        bus_stop();
        check("bad_strobes", (wr_cnt_a - w0) + (rd_cnt_a - r0) + (wr_cnt_b - wb0) +
              (rd_cnt_b - rb0), 0);
        check("bad_busy", (busy_cyc_a - ba0) + (busy_cyc_b - bb0), 0);
        check("bad_sda_low", dut_low_cyc - dl0, 0);

        // Pointer wrap on B (REG_AW=4)
        wb0 = wr_cnt_b;
        bus_start();
        put_byte(8'h54, nak); check("wrap_dev_ack", nak, 1'b0);
        put_byte(8'h0F, nak); check("wrap_reg_ack", nak, 1'b0);
        put_byte(8'h11, nak); check("wrap_d0_ack", nak, 1'b0);
        put_byte(8'h22, nak); check("wrap_d1_ack", nak, 1'b0);
        bus_stop();
        check("wrap_count", wr_cnt_b - wb0, 2);
        check("wrap_wr0", {wb_addr[wb0[3:0]], wb_data[wb0[3:0]]}, 12'hF11);
        check("wrap_wr1", {wb_addr[wb0[3:0] + 4'd1], wb_data[wb0[3:0] + 4'd1]}, 12'h022);
        check("wrap_ptr_end", reg_addr_b, 4'h1);

        // Read through the three-stage synchroniser on B, wrapping the pointer
        rb0 = rd_cnt_b;
        bus_start();
        put_byte(8'h54, nak); check("b_rd_dev_ack", nak, 1'b0);
        put_byte(8'h0E, nak); check("b_rd_reg_ack", nak, 1'b0);
        bus_start();
        put_byte(8'h55, nak); check("b_rd_devr_ack", nak, 1'b0);
        get_byte(d, 1'b1); check("b_rd_byte0", d, 8'hAD);
        get_byte(d, 1'b0); check("b_rd_byte1", d, 8'hAC);
        bus_stop();
        check("b_rd_addrs", {rd_cnt_b - rb0, 24'h0, rb_addr[rb0[3:0]], rb_addr[rb0[3:0] + 4'd1]},
              {32'd2, 24'h0, 8'hEF});
        check("b_rd_ptr_end", reg_addr_b, 4'h0);
        check("bit_stability", unstable, 0);

        // STOP after four data bits
        w0 = wr_cnt_a;
        bus_start();
        put_byte(8'h46, nak); check("abort_dev_ack", nak, 1'b0);
        put_byte(8'h10, nak); check("abort_reg_ack", nak, 1'b0);
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
        bus_stop();
        check("abort_no_wr", wr_cnt_a - w0, 0);
        check("abort_busy", busy_a, 1'b0);
        check("abort_ptr", reg_addr_a, 8'h10);

        // Reset while A drives a low data bit (byte 0x6C from offset 0x30)
        bus_start();
        put_byte(8'h46, nak); check("rst_rd_dev_ack", nak, 1'b0);
        put_byte(8'h30, nak); check("rst_rd_reg_ack", nak, 1'b0);
        bus_start();
        put_byte(8'h47, nak); check("rst_rd_devr_ack", nak, 1'b0);
        for (int i = 2; i >= 0; i--) begin
            get_bit(b);
            bits[i] = b;
        end
        check("rst_rd_bits", bits, 3'b011);
        wait_clk(5);
        check("rst_rd_sda_low", sda, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_sda", sda, 1'b1);
        check("rst_mid_reg_addr", reg_addr_a, 8'h00);
        check("rst_mid_wr_data", wr_data_a, 8'h00);
        check("rst_mid_strobes", {wr_en_a, rd_en_a, busy_a}, 3'b000);
        wait_clk(3);
        rst_n = 1'b1;
        bus_stop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_target_burst.md
# i2c_target_burst

Parametrised I2C target (slave) for the redriver register map: 7-bit device address, one register-offset byte, then multi-byte burst writes or reads with an auto-incrementing register pointer. Handles repeated START for combined write-offset/read transactions and ends reads on master NACK. Sits between the board I2C pins and the local register file, oversampling SCL/SDA on SYSTEM_CLK, and drives a single-cycle write/read strobe interface.

## Interface
- SLAVE_ADDR, 7'h23, 7-bit device address matched after START
- REG_AW, 8, register pointer width (1..8); the low REG_AW bits of the offset byte are used
- SYNC_STAGES, 2, input synchroniser depth for SCL/SDA (>=2)
- SYSTEM_CLK  in  1  system clock; must be >= 10x SCL frequency
- RESETn  in  1  reset, asynchronous, active-low
- SCL  in  1  I2C clock (target never stretches)
- SDA  inout  1  I2C data; driven 1'b0 or released (1'bz) only, never driven high
- rd_data  in  8  register-file read data, valid 1 cycle after rd_en
- reg_addr  out  REG_AW  current register pointer
- wr_data  out  8  last received data byte
- wr_en  out  1  1-cycle write strobe (reg_addr/wr_data valid)
- rd_en  out  1  1-cycle read request at reg_addr
- busy  out  1  high from matched address ACK until STOP/START/NACK

## Operation
- SCL/SDA pass SYNC_STAGES flops; edges from the last two stages. SCL rise = sample SDA; SCL fall = change SDA.
- START: SDA fall while SCL high. STOP: SDA rise while SCL high. Both take priority over every state, release SDA, and clear the bit counter.
- States: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_MACK, WAIT_STOP.
- IDLE -> DEV_ADDR on START. DEV_ADDR shifts 8 bits MSB first (addr[6:0], R/W).
- Address mismatch or address 0x00: no ACK, -> WAIT_STOP (ignore bus until START/STOP).
- Match: DEV_ACK drives SDA=0 for the 9th clock. W -> REG_ADDR. R -> rd_en pulse, -> RD_BYTE.
- REG_ADDR: 8 bits; REG_ACK ACKs and loads pointer = offset[REG_AW-1:0]. -> WR_BYTE.
- WR_BYTE: 8 bits; WR_ACK ACKs; wr_en pulses with wr_data = byte and reg_addr = pointer; pointer increments the following cycle. -> WR_BYTE (burst).
- RD_BYTE: shift register loaded from rd_data 1 cycle after rd_en; pointer increments on load; bits driven MSB first ('1' bits release SDA).
- RD_MACK: SDA released; sample at 9th SCL rise. ACK (0) -> rd_en at 9th SCL fall, -> RD_BYTE. NACK (1) -> WAIT_STOP.
- Repeated START in any state -> DEV_ADDR; pointer preserved (combined format: write offset, Sr, read).
- STOP -> IDLE; pointer preserved.
- Pointer wraps 2^REG_AW-1 -> 0 on both read and write.
- A START/STOP mid-byte discards the partial byte: no wr_en.

## Timing
- Reset values: SDA released, reg_addr=0, wr_data=0, wr_en=0, rd_en=0, busy=0, state IDLE, pointer 0, shift register 0. Reset mid-transfer releases SDA in the same cycle (async).
- Input latency: SYNC_STAGES+1 SYSTEM_CLK from pin to detected edge.
- ACK drive: SDA pulled low <=2 cycles after the detected 8th SCL fall. Released <=2 cycles after the 9th SCL fall.
- wr_en: asserted exactly 1 cycle, on the cycle after the detected 9th SCL fall of WR_ACK.
- rd_en: asserted exactly 1 cycle, on the cycle after the detected address-ACK SCL fall or the master-ACK SCL fall. Shift register loads the next cycle. First bit is on SDA within 3 cycles of that fall.
- Pointer update is visible on reg_addr 1 cycle after wr_en, or after the shift-register load.
- busy: rises with the DEV_ACK drive and falls the cycle after STOP/START/NACK detection.

## Test plan
- Write burst: START, 0x46, 0x10, 0xA5, 0x5A, STOP -> ACK on all four bytes; wr_en twice: (reg_addr 0x10, 0xA5), then (0x11, 0x5A); reg_addr ends at 0x12.
- Combined read: START 0x46 0x20, Sr 0x47, master ACK, ACK, NACK, STOP -> rd_en at 0x20/0x21/0x22; SDA bytes equal the model memory; SDA released after NACK; reg_addr=0x23.
- Wrong address 0x48, then 3 bytes -> no ACK, no strobes, SDA never low, busy stays 0.
- Wrap: REG_AW=4, offset 0x0F, two data bytes -> writes at 0xF then 0x0.
- Abort: STOP after 4 bits of a data byte -> no wr_en, state IDLE. RESETn low mid-read-byte -> SDA released immediately, all outputs at reset values.
- SYNC_STAGES=3 with SCL at SYSTEM_CLK/10 -> every ACK and data bit is stable before the SCL rise.
